hs_src_ctrl: RTL and testbench

Source-side controller for a four-phase req/ack handshake that moves a multi-bit word into another clock domain. It captures a word from a local valid/ready producer and holds it stable on `bus_data`. It then sequences `req` against the far-end `ack`, synchronizing `ack` internally with a SYNC_STAGES flop chain of the DF_SYNC type. It sits beside the asynchronous FIFO in the system and handles low-rate configuration and status words that do not justify a FIFO.

---
 rtl/hs_src_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hs_src_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_src_ctrl.sv
// ---------------------------------------------------------------------------
// hs_src_ctrl
//
// Source side of a four-phase req/ack handshake. It carries one multi-bit
// word into another clock domain. A word is taken from a local valid/ready
// producer and held on bus_data. req is then raised and sequenced against the
// far-end acknowledge. That acknowledge is brought into clk through a
// SYNC_STAGES flop chain. Each handshake phase is guarded by an optional
// timeout. When the timeout expires, req is dropped and the sticky err flag
// is raised.
//
// Parameters:
//   DATA_WIDTH      width of the transferred word
//   SYNC_STAGES     flops in the ack synchronizer (2 or more)
//   TIMEOUT_CYCLES  cycles allowed per handshake phase, 0 disables the timeout
//
// Ports:
//   clk        source-domain clock
//   rst        asynchronous reset, active-low
//   in_valid   producer has a word
//   in_data    producer word
//   in_ready   controller accepts a word this cycle (high only in IDLE)
//   ack_async  far-end acknowledge, asynchronous to clk
//   req        handshake request (registered)
//   bus_data   word held for the far end (registered)
//   xfer_done  one-cycle pulse when a handshake completes normally
//   err_clr    clears err at the next edge
//   err        sticky timeout flag
//   busy       high whenever the controller is not in IDLE
// ---------------------------------------------------------------------------
module hs_src_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  ack_async,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  xfer_done,
  input  logic                  err_clr,
  output logic                  err,
  output logic                  busy
);

  // The counter keeps at least one bit so that the design still elaborates
  // when the timeout is disabled. In that case the counter value is never
  // used.
  localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HI   = 2'd1,
    REQ_LO   = 2'd2,
    ERR_WAIT = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // ack synchronizer: stage 0 samples the asynchronous input. The FSM only
  // ever looks at the last stage.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ack_sync_reg;
  logic                   ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_s = ack_sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  logic                    req_reg, req_next;
  logic [DATA_WIDTH-1:0]   bus_data_reg, bus_data_next;
  logic                    xfer_done_reg, xfer_done_next;
  logic                    err_reg, err_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    at_limit;
  logic                    timeout_hit;

  // The counter holds the number of edges already spent in the current
  // phase. When it reads TIMEOUT_CYCLES-1 and the phase still has not
  // ended, the next edge is edge number TIMEOUT_CYCLES of the phase.
  assign at_limit = TIMEOUT_EN && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    bus_data_next  = bus_data_reg;
    xfer_done_next = 1'b0;
    err_next       = err_reg;
    cnt_next       = cnt_reg;
    timeout_hit    = 1'b0;

    if (err_clr) begin
      err_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          bus_data_next = in_data;
          req_next      = 1'b1;
          cnt_next      = '0;
          state_next    = REQ_HI;
        end
      end
      REQ_HI: begin
        // The normal exit is checked first, so it takes precedence over a
        // timeout that falls in the same cycle.
        if (ack_s) begin
          req_next   = 1'b0;
          cnt_next   = '0;
          state_next = REQ_LO;
        end else if (at_limit) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          xfer_done_next = 1'b1;
          cnt_next       = '0;
          state_next     = IDLE;
        end else if (at_limit) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ERR_WAIT: begin
        // Wait for the far end to release ack, so that the next request
        // starts from a clean low-low state.
        if (!ack_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // A timeout sets err even when err_clr is high in the same cycle.
    if (timeout_hit) begin
      req_next   = 1'b0;
      err_next   = 1'b1;
      cnt_next   = '0;
      state_next = ERR_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      bus_data_reg  <= '0;
      xfer_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      bus_data_reg  <= bus_data_next;
      xfer_done_reg <= xfer_done_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign req       = req_reg;
  assign bus_data  = bus_data_reg;
  assign xfer_done = xfer_done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_hs_src_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hs_src_ctrl
//
// Scoreboard bench for hs_src_ctrl. The stimulus side pushes expectations
// into queues: accepted words and their accept edges, req-fall edges,
// xfer_done edges, return-to-idle edges and err edges. The far-end model
// pushes the edges that follow from the ack timing rules. A separate
// monitor pops the expectations and compares them whenever the DUT shows
// the matching event. Edge numbers count rising clock edges. The bench
// samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_hs_src_ctrl;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TOUT = 10;

  localparam int FE_NORMAL = 0;
  localparam int FE_FORCE  = 1;
  localparam int FE_TOGGLE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          ack_async;
  logic          req;
  logic [DW-1:0] bus_data;
  logic          xfer_done;
  logic          err_clr;
  logic          err;
  logic          busy;

  hs_src_ctrl #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ack_async(ack_async),
    .req      (req),
    .bus_data (bus_data),
    .xfer_done(xfer_done),
    .err_clr  (err_clr),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done_total = 0;

  logic [DW-1:0] exp_word_q[$];
  int            accept_q[$];
  int            exp_req_fall_q[$];
  int            exp_done_q[$];
  int            exp_idle_q[$];
  int            exp_err_q[$];

  int fe_mode = FE_TOGGLE;
  bit fe_level = 1'b0;
  bit fe_push_idle = 1'b0;
  int fe_dhi = 0;
  int fe_dlo = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Far-end model. It runs on the falling edge, so every change it makes is
  // first sampled at the next rising edge (cyc+1).
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    ack_async = 1'b0;
    forever begin
      @(negedge clk);
      if (fe_mode == FE_TOGGLE) begin
        ack_async = ~ack_async;
      end else if (fe_mode == FE_FORCE) begin
        if (ack_async && !fe_level && fe_push_idle) begin
          exp_idle_q.push_back(cyc + 1 + SYNC);
        end
        ack_async = fe_level;
      end else begin
        if (!ack_async && req) begin
          if (wait_cnt >= fe_dhi) begin
            ack_async = 1'b1;
            wait_cnt  = 0;
            // ack is sampled at edge cyc+1. req must fall SYNC edges later.
            exp_req_fall_q.push_back(cyc + 1 + SYNC);
          end else begin
            wait_cnt++;
          end
        end else if (ack_async && !req) begin
          if (wait_cnt >= fe_dlo) begin
            ack_async = 1'b0;
            wait_cnt  = 0;
            // The low ack is sampled at edge B = cyc+1. Completion and idle
            // both follow at edge B+SYNC.
            exp_done_q.push_back(cyc + 1 + SYNC);
            exp_idle_q.push_back(cyc + 1 + SYNC);
            exp_done_total++;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT shows the matching event.
  initial begin
    bit            prev_busy;
    bit            prev_req;
    bit            prev_err;
    logic [DW-1:0] cur_word;
    int            e;
    prev_busy = 1'b0;
    prev_req  = 1'b0;
    prev_err  = 1'b0;
    cur_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_busy = 1'b0;
        prev_req  = 1'b0;
        prev_err  = 1'b0;
        cur_word  = '0;
      end else begin
        if (busy && !prev_busy) begin
          check(exp_word_q.size() != 0, "accept_expected", exp_word_q.size(), 1);
          if (exp_word_q.size() != 0 && accept_q.size() != 0) begin
            cur_word = exp_word_q.pop_front();
            e = accept_q.pop_front();
            check(cyc == e, "accept_edge", cyc, e);
            check(req == 1'b1, "req_on_accept", req, 1);
          end
        end
        check(bus_data == cur_word, "bus_data_hold", bus_data, cur_word);
        check(in_ready == !busy, "in_ready_vs_busy", in_ready, !busy);
        if (!busy) begin
          check(req == 1'b0, "req_low_in_idle", req, 0);
        end
        if (prev_req && !req) begin
          check(exp_req_fall_q.size() != 0, "req_fall_expected", exp_req_fall_q.size(), 1);
          if (exp_req_fall_q.size() != 0) begin
            e = exp_req_fall_q.pop_front();
            check(cyc == e, "req_fall_edge", cyc, e);
          end
        end
        if (xfer_done) begin
          done_cnt++;
          check(!busy, "done_in_idle", busy, 0);
          check(exp_done_q.size() != 0, "done_expected", exp_done_q.size(), 1);
          if (exp_done_q.size() != 0) begin
            e = exp_done_q.pop_front();
            check(cyc == e, "done_edge", cyc, e);
          end
        end
        if (prev_busy && !busy) begin
          check(exp_idle_q.size() != 0, "idle_expected", exp_idle_q.size(), 1);
          if (exp_idle_q.size() != 0) begin
            e = exp_idle_q.pop_front();
            check(cyc == e, "idle_edge", cyc, e);
          end
        end
        if (err && !prev_err) begin
          check(exp_err_q.size() != 0, "err_expected", exp_err_q.size(), 1);
          if (exp_err_q.size() != 0) begin
            e = exp_err_q.pop_front();
            check(cyc == e, "err_edge", cyc, e);
          end
        end
        prev_busy = busy;
        prev_req  = req;
        prev_err  = err;
      end
    end
  end

  // Offers one word, starting on a falling edge. Returns on the falling edge
  // that follows the accept edge.
  task automatic send(input logic [DW-1:0] w, input bit keep, output int acc_edge);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_edge = -1;
    if (!in_ready) begin
      check(in_ready == 1'b1, "accept_wait", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      acc_edge = cyc + 1;
      exp_word_q.push_back(w);
      accept_q.push_back(acc_edge);
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(!busy, "idle_wait", busy, 0);
  endtask

  initial begin
    int acc;
    int prev_acc;
    int done_before;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;

    // Reset: ack toggles while reset is held low.
    repeat (4) begin
      @(negedge clk);
      check(req == 1'b0, "rst_req", req, 0);
      check(bus_data == '0, "rst_bus_data", bus_data, 0);
      check(xfer_done == 1'b0, "rst_xfer_done", xfer_done, 0);
      check(err == 1'b0, "rst_err", err, 0);
      check(busy == 1'b0, "rst_busy", busy, 0);
      check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    end
    fe_mode  = FE_FORCE;
    fe_level = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    check(busy == 1'b0, "idle_after_reset", busy, 0);
    check(in_ready == 1'b1, "ready_after_reset", in_ready, 1);

    // Single transfer of 0xA5. A second word (0x3C) is offered while busy.
    fe_dhi  = 3;
    fe_dlo  = 3;
    fe_mode = FE_NORMAL;
    done_before = done_cnt;
    send(8'hA5, 1'b0, acc);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check(done_cnt - done_before == 1, "single_done_count", done_cnt - done_before, 1);

    // Back-to-back 0x01..0x10 with a zero-delay far end. Accept N, ack
    // sampled N+1, req falls N+1+SYNC, ack low sampled N+2+SYNC, done at
    // N+2+2*SYNC, next accept one edge later. That is the 2*SYNC+2 source
    // cost plus one cycle of far-end reaction.
    fe_dhi = 0;
    fe_dlo = 0;
    done_before = done_cnt;
    prev_acc = 0;
    for (int k = 1; k <= 16; k++) begin
      send(k[DW-1:0], 1'b1, acc);
      if (k > 1) check(acc - prev_acc == 2 * SYNC + 3, "b2b_spacing", acc - prev_acc, 2 * SYNC + 3);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check(done_cnt - done_before == 16, "b2b_done_count", done_cnt - done_before, 16);

    // REQ_HI timeout with ack stuck at 0.
    fe_mode  = FE_FORCE;
    fe_level = 1'b0;
    @(negedge clk);
    done_before = done_cnt;
    send(8'hC3, 1'b0, acc);
    exp_req_fall_q.push_back(acc + TOUT);
    exp_err_q.push_back(acc + TOUT);
    exp_idle_q.push_back(acc + TOUT + 1);
    wait_idle();
    repeat (2) @(negedge clk);
    check(done_cnt == done_before, "hi_timeout_no_done", done_cnt - done_before, 0);
    check(err == 1'b1, "hi_timeout_err", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check(err == 1'b0, "err_clr_after_hi", err, 0);

    // REQ_LO timeout with ack stuck at 1.
    fe_level = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    done_before = done_cnt;
    send(8'h96, 1'b0, acc);
    exp_req_fall_q.push_back(acc + 1);
    exp_err_q.push_back(acc + 1 + TOUT);
    while (!err && cyc < acc + 3 * TOUT) @(negedge clk);
    check(err == 1'b1, "lo_timeout_err", err, 1);
    repeat (5) begin
      @(negedge clk);
      check(busy == 1'b1, "err_wait_busy", busy, 1);
      check(req == 1'b0, "err_wait_req", req, 0);
      check(err == 1'b1, "err_wait_err", err, 1);
    end
    fe_push_idle = 1'b1;
    fe_level     = 1'b0;
    wait_idle();
    fe_push_idle = 1'b0;
    repeat (2) @(negedge clk);
    check(done_cnt == done_before, "lo_timeout_no_done", done_cnt - done_before, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check(err == 1'b0, "err_clr_after_lo", err, 0);

    // err_clr in the same cycle as a new timeout: the set wins.
    send(8'h69, 1'b0, acc);
    exp_req_fall_q.push_back(acc + TOUT);
    exp_err_q.push_back(acc + TOUT);
    exp_idle_q.push_back(acc + TOUT + 1);
    while (cyc < acc + TOUT - 1) @(negedge clk);
    check(err == 1'b0, "err_before_collision", err, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check(err == 1'b1, "err_set_beats_clr", err, 1);
    wait_idle();

    // Reset in the middle of REQ_HI.
    send(8'h77, 1'b0, acc);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check(req == 1'b0, "midrst_req_async", req, 0);
    check(bus_data == '0, "midrst_bus_data", bus_data, 0);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(err == 1'b0, "midrst_err", err, 0);
    @(negedge clk);
    exp_req_fall_q.delete();
    exp_err_q.delete();
    exp_idle_q.delete();
    @(negedge clk);
    rst = 1'b1;
    fe_dhi  = 2;
    fe_dlo  = 1;
    fe_mode = FE_NORMAL;
    repeat (2) @(negedge clk);
    done_before = done_cnt;
    send(8'h5A, 1'b0, acc);
    wait_idle();
    repeat (2) @(negedge clk);
    check(done_cnt - done_before == 1, "post_rst_done", done_cnt - done_before, 1);
    check(bus_data == 8'h5A, "post_rst_word", bus_data, 8'h5A);

    // Randomized transfers with random far-end delays and idle gaps.
    for (int k = 0; k < 24; k++) begin
      fe_dhi = $urandom_range(0, 4);
      fe_dlo = $urandom_range(0, 4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom), 1'b0, acc);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check(done_cnt == exp_done_total, "total_done", done_cnt, exp_done_total);
    check(exp_word_q.size() == 0, "words_left", exp_word_q.size(), 0);
    check(exp_req_fall_q.size() == 0, "req_falls_left", exp_req_fall_q.size(), 0);
    check(exp_done_q.size() == 0, "dones_left", exp_done_q.size(), 0);
    check(exp_idle_q.size() == 0, "idles_left", exp_idle_q.size(), 0);
    check(exp_err_q.size() == 0, "errs_left", exp_err_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before %0d edges", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
